ecc_apb_sequencer: RTL

ECC_APB_SEQUENCER -- requirements
Module: ecc_apb_sequencer

---
 rtl/ecc_seq_pkg.sv | 41 ++++
 rtl/ecc_seq_apb_master.sv | 58 +++++
 rtl/ecc_apb_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ecc_seq_pkg.sv
// Shared definitions for the ECC APB sequencer: ECC_ENC_DEC register map, op codes, state encodings.
package ecc_seq_pkg;

    localparam logic [7:0] REG_CTRL           = 8'h00;
    localparam logic [7:0] REG_DATA_IN        = 8'h04;
    localparam logic [7:0] REG_CODEWORD_WIDTH = 8'h08;
    localparam logic [7:0] REG_NOISE          = 8'h0C;

    localparam logic [1:0] LAST_WRITE_IDX = 2'd3;

    typedef enum logic [1:0] {
        OP_ENCODE  = 2'd0,
        OP_DECODE  = 2'd1,
        OP_FULL    = 2'd2,
        OP_ILLEGAL = 2'd3
    } ecc_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_DONE,
        ST_RESP
    } seq_state_e;

    typedef enum logic {
        PH_IDLE,
        PH_ACCESS
    } apb_phase_e;

    // CTRL goes last because writing it kicks off the ECC engine.
    function automatic logic [7:0] write_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    write_offset = REG_DATA_IN;
            2'd1:    write_offset = REG_CODEWORD_WIDTH;
            2'd2:    write_offset = REG_NOISE;
            default: write_offset = REG_CTRL;
        endcase
    endfunction

endpackage

// File: rtl/ecc_seq_apb_master.sv
// Two-phase APB write driver: start_i marks the SETUP cycle, the following cycle is ACCESS (done_o).
module ecc_seq_apb_master
    import ecc_seq_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [AMBA_ADDR_WIDTH-1:0] addr_i,
    input  logic [AMBA_WORD-1:0]       wdata_i,
    output logic                       done_o,
    output logic [AMBA_ADDR_WIDTH-1:0] paddr_o,
    output logic [AMBA_WORD-1:0]       pwdata_o,
    output logic                       psel_o,
    output logic                       penable_o,
    output logic                       pwrite_o
);

    apb_phase_e                 phase_q, phase_d;
    logic [AMBA_ADDR_WIDTH-1:0] addr_q;
    logic [AMBA_WORD-1:0]       wdata_q;
    logic                       setup;

    always_comb begin
        setup     = start_i && (phase_q == PH_IDLE);
        phase_d   = setup ? PH_ACCESS : PH_IDLE;
        psel_o    = setup || (phase_q == PH_ACCESS);
        penable_o = (phase_q == PH_ACCESS);
        pwrite_o  = psel_o;
        done_o    = penable_o;
        paddr_o   = '0;
        pwdata_o  = '0;
        if (setup) begin
            paddr_o  = addr_i;
            pwdata_o = wdata_i;
        end else if (phase_q == PH_ACCESS) begin
            paddr_o  = addr_q;
            pwdata_o = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= PH_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            phase_q <= phase_d;
            if (setup) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/ecc_apb_sequencer.sv
// Runs one ECC_ENC_DEC operation per request: four APB writes, wait for operation_done, return result.
// Define ECC_SEQ_TIMEOUT_EN to add a watchdog on the wait for operation_done.
module ecc_apb_sequencer
    import ecc_seq_pkg::*;
#(
    parameter int          DATA_WIDTH      = 32,
    parameter int          AMBA_ADDR_WIDTH = 20,
    parameter int          AMBA_WORD       = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [AMBA_WORD-1:0]       req_data,
    input  logic [AMBA_WORD-1:0]       req_noise,
    input  logic [1:0]                 req_width,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic                       rsp_timeout,
    output logic                       busy
);

    seq_state_e                 state_q, state_d;
    logic [1:0]                 idx_q, idx_d;
    ecc_op_e                    op_q, op_d;
    logic [1:0]                 width_q, width_d;
    logic [AMBA_WORD-1:0]       data_q, data_d;
    logic [AMBA_WORD-1:0]       noise_q, noise_d;
    logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [1:0]                 rsp_errors_q, rsp_errors_d;
    logic                       apb_done;
    logic [AMBA_ADDR_WIDTH-1:0] wr_addr;
    logic [AMBA_WORD-1:0]       wr_data;
`ifdef ECC_SEQ_TIMEOUT_EN
    logic                       rsp_timeout_q, rsp_timeout_d;
    logic [31:0]                wdog_q, wdog_d;
`else
    // Keeps the watchdog limit referenced when the watchdog is compiled out.
    logic [31:0]                unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

    always_comb begin
        wr_addr = AMBA_ADDR_WIDTH'(write_offset(idx_q));
        case (idx_q)
            2'd0:    wr_data = data_q;
            2'd1:    wr_data = AMBA_WORD'(width_q);
            2'd2:    wr_data = noise_q;
            default: wr_data = AMBA_WORD'(op_q);
        endcase
    end

    ecc_seq_apb_master #(
        .AMBA_ADDR_WIDTH(AMBA_ADDR_WIDTH),
        .AMBA_WORD      (AMBA_WORD)
    ) u_apb_master (
        .clk      (clk),
        .rst      (rst),
        .start_i  (state_q == ST_SETUP),
        .addr_i   (wr_addr),
        .wdata_i  (wr_data),
        .done_o   (apb_done),
        .paddr_o  (PADDR),
        .pwdata_o (PWDATA),
        .psel_o   (PSEL),
        .penable_o(PENABLE),
        .pwrite_o (PWRITE)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        op_d         = op_q;
        width_d      = width_q;
        data_d       = data_q;
        noise_d      = noise_q;
        rsp_data_d   = rsp_data_q;
        rsp_errors_d = rsp_errors_q;
`ifdef ECC_SEQ_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
        wdog_d        = wdog_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = ecc_op_e'(req_op);
                    width_d = req_width;
                    data_d  = req_data;
                    noise_d = req_noise;
                    idx_d   = 2'd0;
                    if (ecc_op_e'(req_op) == OP_ILLEGAL) begin
                        rsp_data_d   = '0;
                        rsp_errors_d = 2'b11;
`ifdef ECC_SEQ_TIMEOUT_EN
                        rsp_timeout_d = 1'b0;
`endif
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (apb_done) begin
                    if (idx_q == LAST_WRITE_IDX) begin
                        state_d = ST_WAIT_DONE;
`ifdef ECC_SEQ_TIMEOUT_EN
                        wdog_d = '0;
`endif
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (operation_done) begin
                    rsp_data_d   = data_out;
                    rsp_errors_d = num_of_errors;
`ifdef ECC_SEQ_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d = ST_RESP;
                end
`ifdef ECC_SEQ_TIMEOUT_EN
                else if (wdog_q + 32'd1 >= TIMEOUT_CYCLES) begin
                    rsp_data_d    = '0;
                    rsp_errors_d  = 2'b00;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            op_q         <= OP_ENCODE;
            width_q      <= 2'd0;
            data_q       <= '0;
            noise_q      <= '0;
            rsp_data_q   <= '0;
            rsp_errors_q <= 2'b00;
`ifdef ECC_SEQ_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
            wdog_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            width_q      <= width_d;
            data_q       <= data_d;
            noise_q      <= noise_d;
            rsp_data_q   <= rsp_data_d;
            rsp_errors_q <= rsp_errors_d;
`ifdef ECC_SEQ_TIMEOUT_EN
            rsp_timeout_q <= rsp_timeout_d;
            wdog_q        <= wdog_d;
`endif
        end
    end

    assign req_ready  = rst && (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_data   = rsp_data_q;
    assign rsp_errors = rsp_errors_q;
`ifdef ECC_SEQ_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule
